// File: rtl/key_schedule_seq_if.sv
// Handshake/data bundle between an AES key-schedule sequencer and the logic that
// starts it, supplies the external S-box result and consumes the round keys.
interface key_schedule_seq_if;
  logic         start_in;
  logic [1:0]   key_len_in;
  logic [255:0] key_in;
  logic [31:0]  subword_out;
  logic [31:0]  subword_in;
  logic [127:0] round_key_out;
  logic         round_key_valid_out;
  logic         round_key_ready_in;
  logic [3:0]   round_idx_out;
  logic         busy_out;
  logic         done_out;
  logic         err_out;

  modport slave (
    input  start_in, key_len_in, key_in, subword_in, round_key_ready_in,
    output subword_out, round_key_out, round_key_valid_out, round_idx_out,
           busy_out, done_out, err_out
  );

  modport master (
    output start_in, key_len_in, key_in, subword_in, round_key_ready_in,
    input  subword_out, round_key_out, round_key_valid_out, round_idx_out,
           busy_out, done_out, err_out
  );
endinterface

// File: rtl/key_schedule_seq.sv
// AES-128/192/256 key expansion, one word per step, presenting each 128-bit round
// key behind a valid/ready handshake. The S-box array lives outside this block.
module key_schedule_seq #(
  parameter int MAX_KEY_BITS = 256,
  parameter int SBOX_REG     = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  key_schedule_seq_if.slave ks
);

  typedef enum logic [2:0] {IDLE, GEN, SBWAIT, HOLD, FIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  phase_q, phase_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [31:0] stg_q [4];
  logic [31:0] stg_d [4];
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] subword_q, subword_d;

  logic [31:0] key_w [8];
  logic [31:0] win_load [8];
  logic [3:0]  load_base;
  logic [2:0]  load_rot;
  logic [3:0]  nk;
  logic [3:0]  nr;
  logic [31:0] old_w;
  logic [31:0] new_w;
  logic [31:0] s_rot;
  logic        len_ok;
  logic        write_en;

  genvar gi;

  // The window keeps the newest word in slot 7, so w[i-1] is always win_q[7] and
  // w[i-Nk] is win_q[8-Nk]. Key words are preloaded so that the first Nk shifts
  // simply replay the cipher key.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key
      assign key_w[gi]    = ks.key_in[32*gi +: 32];
      assign win_load[gi] = (4'(gi) >= load_base) ? key_w[3'(gi) + load_rot] : '0;
    end
  endgenerate

  always_comb begin
    load_base = 4'd4;
    load_rot  = 3'd4;
    len_ok    = 1'b0;
    case (ks.key_len_in)
      2'b00: begin
        len_ok = 1'b1;
      end
      2'b01: begin
        load_base = 4'd2;
        load_rot  = 3'd6;
        len_ok    = (MAX_KEY_BITS >= 192);
      end
      2'b10: begin
        load_base = 4'd0;
        load_rot  = 3'd0;
        len_ok    = (MAX_KEY_BITS >= 256);
      end
      default: len_ok = 1'b0;
    endcase
  end

  always_comb begin
    nk    = 4'd4;
    nr    = 4'd10;
    old_w = win_q[4];
    case (mode_q)
      2'b01: begin
        nk    = 4'd6;
        nr    = 4'd12;
        old_w = win_q[2];
      end
      2'b10: begin
        nk    = 4'd8;
        nr    = 4'd14;
        old_w = win_q[0];
      end
      default: ;
    endcase
  end

  // SubWord(RotWord(x)) == RotWord(SubWord(x)), so rotate the returned S-box word.
  assign s_rot = {ks.subword_in[7:0], ks.subword_in[31:8]};

  always_comb begin
    if (i_q < {2'b00, nk}) begin
      new_w = old_w;
    end else if (phase_q == 3'd0) begin
      new_w = old_w ^ s_rot ^ {24'h0, rcon_q};
    end else if (nk == 4'd8 && phase_q == 3'd4) begin
      new_w = old_w ^ ks.subword_in;
    end else begin
      new_w = old_w ^ win_q[7];
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    i_d      = i_q;
    phase_d  = phase_q;
    rcon_d   = rcon_q;
    win_d    = win_q;
    stg_d    = stg_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    write_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (ks.start_in) begin
          if (len_ok) begin
            mode_d  = ks.key_len_in;
            win_d   = win_load;
            i_d     = 6'd0;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            state_d = GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GEN: begin
        if (SBOX_REG != 0) begin
          state_d = SBWAIT;
        end else begin
          write_en = 1'b1;
        end
      end
      SBWAIT: write_en = 1'b1;
      HOLD: begin
        if (valid_q && ks.round_key_ready_in) begin
          valid_d = 1'b0;
          if (idx_q == nr) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = GEN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (write_en) begin
      stg_d[i_q[1:0]] = new_w;
      for (int k = 0; k < 7; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[7] = new_w;
      i_d      = i_q + 6'd1;
      phase_d  = ({1'b0, phase_q} == nk - 4'd1) ? 3'd0 : phase_q + 3'd1;
      if (i_q >= {2'b00, nk} && phase_q == 3'd0) begin
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      if (i_q[1:0] == 2'b11) begin
        state_d = HOLD;
        valid_d = 1'b1;
        idx_d   = i_q[5:2];
      end else begin
        state_d = GEN;
      end
    end

    busy_d    = (state_d != IDLE);
    subword_d = (state_d == GEN || state_d == SBWAIT) ? win_d[7] : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      i_q       <= 6'd0;
      phase_q   <= 3'd0;
      rcon_q    <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        stg_q[k] <= '0;
      end
      idx_q     <= 4'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      subword_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      i_q       <= i_d;
      phase_q   <= phase_d;
      rcon_q    <= rcon_d;
      win_q     <= win_d;
      stg_q     <= stg_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      subword_q <= subword_d;
    end
  end

  assign ks.round_key_out       = {stg_q[3], stg_q[2], stg_q[1], stg_q[0]};
  assign ks.round_key_valid_out = valid_q;
  assign ks.round_idx_out       = idx_q;
  assign ks.busy_out            = busy_q;
  assign ks.done_out            = done_q;
  assign ks.err_out             = err_q;
  assign ks.subword_out         = subword_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 vectors, backpressure, rejected starts and
// mid-run reset, with round keys checked against a software expansion model.
module tb_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_schedule_seq_if ks();
  key_schedule_seq_if ks192();

  key_schedule_seq #(.MAX_KEY_BITS(256), .SBOX_REG(0)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .ks(ks)
  );

  key_schedule_seq #(.MAX_KEY_BITS(192), .SBOX_REG(0)) u_dut192 (
    .clk_in(clk), .rst_n_in(rst_n), .ks(ks192)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           done_cnt = 0;
  int           err_cnt = 0;
  logic [127:0] last_key = '0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'hdeadbeef_0badf00d_cafebabe_12345678};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hfeedface_a5a5a5a5};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon_f(input int n);
    case (n)
      1: return 8'h01;   2: return 8'h02;   3: return 8'h04;   4: return 8'h08;
      5: return 8'h10;   6: return 8'h20;   7: return 8'h40;   8: return 8'h80;
      9: return 8'h1b;  10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [255:0] dut_key(input logic [255:0] fk);
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = bswap(fk[255-32*j -: 32]);
    return k;
  endfunction

  assign ks.subword_in    = sub_word(ks.subword_out);
  assign ks192.subword_in = sub_word(ks192.subword_out);

  // FIPS-197 textbook expansion in big-endian word notation, converted to DUT layout.
  task automatic push_expected(input logic [1:0] len, input logic [255:0] fk);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk;
    int nr;
    exp_t e;
    nk = 4 + 2 * int'(len);
    nr = nk + 6;
    for (int j = 0; j < nk; j++) w[j] = fk[255-32*j -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_f(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.key = {bswap(w[4*r+3]), bswap(w[4*r+2]), bswap(w[4*r+1]), bswap(w[4*r])};
      e.idx = 4'(r);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (ks.done_out) done_cnt++;
    if (ks.err_out) err_cnt++;
    if (ks.round_key_valid_out && ks.round_key_ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL key_unexpected idx got=%0d key got=%h want=none", ks.round_idx_out, ks.round_key_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (ks.round_key_out !== mon_e.key || ks.round_idx_out !== mon_e.idx) begin
          bad++;
          $display("FAIL round_key idx got=%0d want=%0d key got=%h want=%h",
                   ks.round_idx_out, mon_e.idx, ks.round_key_out, mon_e.key);
        end
        $display("key idx=%0d key=%h", ks.round_idx_out, ks.round_key_out);
      end
      last_key = ks.round_key_out;
    end
  end

  task automatic start_run(input logic [1:0] len, input logic [255:0] fk);
    @(posedge clk);
    #1;
    ks.start_in   = 1'b1;
    ks.key_len_in = len;
    ks.key_in     = dut_key(fk);
    push_expected(len, fk);
    @(posedge clk);
    #1;
    ks.start_in = 1'b0;
    ks.key_in   = {8{$urandom()}};
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_key(input logic [3:0] idx, input int budget);
    for (int c = 0; c < budget && !(ks.round_key_valid_out && ks.round_idx_out == idx); c++)
      @(negedge clk);
  endtask

  task automatic test_reset();
    ks.start_in = 1'b0; ks.key_len_in = 2'b00; ks.key_in = '0; ks.round_key_ready_in = 1'b0;
    ks192.start_in = 1'b0; ks192.key_len_in = 2'b00; ks192.key_in = '0; ks192.round_key_ready_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (ks.round_key_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ks.round_key_valid_out); end
    total++; if (ks.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ks.busy_out); end
    total++; if (ks.done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", ks.done_out); end
    total++; if (ks.err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", ks.err_out); end
    total++; if (ks.round_idx_out !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", ks.round_idx_out); end
    total++; if (ks.round_key_out !== 128'd0) begin bad++; $display("FAIL reset_key got=%h want=0", ks.round_key_out); end
    total++; if (ks.subword_out !== 32'd0) begin bad++; $display("FAIL reset_subword got=%h want=0", ks.subword_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_aes128();
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [127:0] k10 = {bswap(32'hb6630ca6), bswap(32'he13f0cc8), bswap(32'hc9ee2589), bswap(32'hd014f9a8)};
    ks.round_key_ready_in = 1'b1;
    start_run(2'b00, KEY128);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ks.round_key_valid_out !== 1'b0 || ks.busy_out !== 1'b1) begin bad++;
      $display("FAIL aes128_early_valid valid got=%b want=0 busy got=%b want=1", ks.round_key_valid_out, ks.busy_out); end
    @(posedge clk);
    @(negedge clk);
    total++; if (ks.round_key_valid_out !== 1'b1 || ks.round_idx_out !== 4'd0) begin bad++;
      $display("FAIL aes128_first_latency valid got=%b want=1 idx got=%0d want=0", ks.round_key_valid_out, ks.round_idx_out); end
    @(posedge clk);
    #1 ks.start_in = 1'b1; ks.key_len_in = 2'b11;
    @(posedge clk);
    #1 ks.start_in = 1'b0;
    wait_done(300, d0);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL aes128_done got=%0d want=%0d", done_cnt - d0, 1); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL aes128_busy_start_err got=%0d want=0", err_cnt - e0); end
    total++; if (ks.busy_out !== 1'b0) begin bad++; $display("FAIL aes128_idle_busy got=%b want=0", ks.busy_out); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL aes128_keys_left got=%0d want=0", exp_q.size()); end
    total++; if (last_key !== k10) begin bad++; $display("FAIL aes128_key10 got=%h want=%h", last_key, k10); end
    $display("aes128 run complete");
  endtask

  task automatic test_aes192();
    int d0 = done_cnt;
    ks.round_key_ready_in = 1'b1;
    start_run(2'b01, KEY192);
    wait_done(400, d0);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL aes192_done got=%0d want=1", done_cnt - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL aes192_keys_left got=%0d want=0", exp_q.size()); end
    total++; if (last_key[127:96] !== bswap(32'h01002202)) begin bad++;
      $display("FAIL aes192_w51 got=%h want=%h", last_key[127:96], bswap(32'h01002202)); end
    $display("aes192 run complete");
  endtask

  task automatic test_aes256();
    int d0 = done_cnt;
    ks.round_key_ready_in = 1'b1;
    start_run(2'b10, KEY256);
    wait_done(400, d0);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL aes256_done got=%0d want=1", done_cnt - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL aes256_keys_left got=%0d want=0", exp_q.size()); end
    total++; if (last_key[127:96] !== bswap(32'h706c631e)) begin bad++;
      $display("FAIL aes256_w59 got=%h want=%h", last_key[127:96], bswap(32'h706c631e)); end
    $display("aes256 run complete");
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    logic [127:0] snap;
    ks.round_key_ready_in = 1'b1;
    start_run(2'b00, KEY128);
    wait_key(4'd2, 100);
    @(posedge clk);
    #1 ks.round_key_ready_in = 1'b0;
    wait_key(4'd3, 20);
    total++; if (ks.round_key_valid_out !== 1'b1 || ks.round_idx_out !== 4'd3) begin bad++;
      $display("FAIL bp_key3_valid valid got=%b want=1 idx got=%0d want=3", ks.round_key_valid_out, ks.round_idx_out); end
    snap = ks.round_key_out;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (ks.round_key_out !== snap || ks.round_idx_out !== 4'd3 || ks.round_key_valid_out !== 1'b1 || ks.subword_out !== 32'd0) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d key got=%h want=%h idx got=%0d want=3 valid got=%b want=1 subword got=%h want=0",
                 c, ks.round_key_out, snap, ks.round_idx_out, ks.round_key_valid_out, ks.subword_out);
      end
    end
    @(posedge clk);
    #1 ks.round_key_ready_in = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ks.round_key_valid_out !== 1'b0) begin bad++; $display("FAIL bp_key4_early valid got=%b want=0", ks.round_key_valid_out); end
    @(posedge clk);
    @(negedge clk);
    total++; if (ks.round_key_valid_out !== 1'b1 || ks.round_idx_out !== 4'd4) begin bad++;
      $display("FAIL bp_key4_latency valid got=%b want=1 idx got=%0d want=4", ks.round_key_valid_out, ks.round_idx_out); end
    wait_done(300, d0);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_keys_left got=%0d want=0", exp_q.size()); end
    $display("backpressure run complete");
  endtask

  task automatic test_errors();
    int e0 = err_cnt;
    @(posedge clk);
    #1 ks.start_in = 1'b1; ks.key_len_in = 2'b11;
       ks192.start_in = 1'b1; ks192.key_len_in = 2'b10;
    @(posedge clk);
    #1 ks.start_in = 1'b0; ks192.start_in = 1'b0;
    @(negedge clk);
    total++; if (ks.err_out !== 1'b1 || ks.busy_out !== 1'b0) begin bad++;
      $display("FAIL err_len11 err got=%b want=1 busy got=%b want=0", ks.err_out, ks.busy_out); end
    total++; if (ks192.err_out !== 1'b1 || ks192.busy_out !== 1'b0) begin bad++;
      $display("FAIL err_max192 err got=%b want=1 busy got=%b want=0", ks192.err_out, ks192.busy_out); end
    @(negedge clk);
    total++; if (ks.err_out !== 1'b0 || ks192.err_out !== 1'b0 || ks.busy_out !== 1'b0 || ks192.busy_out !== 1'b0) begin bad++;
      $display("FAIL err_one_pulse err got=%b/%b want=0/0 busy got=%b/%b want=0/0",
               ks.err_out, ks192.err_out, ks.busy_out, ks192.busy_out); end
    repeat (3) @(negedge clk);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL err_count got=%0d want=1", err_cnt - e0); end
    $display("error starts complete");
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [127:0] k10 = {bswap(32'hb6630ca6), bswap(32'he13f0cc8), bswap(32'hc9ee2589), bswap(32'hd014f9a8)};
    ks.round_key_ready_in = 1'b1;
    start_run(2'b00, KEY128);
    wait_key(4'd4, 100);
    @(posedge clk);
    #1 ks.round_key_ready_in = 1'b0;
    wait_key(4'd5, 20);
    total++; if (ks.round_key_valid_out !== 1'b1 || ks.round_idx_out !== 4'd5) begin bad++;
      $display("FAIL rst_hold5 valid got=%b want=1 idx got=%0d want=5", ks.round_key_valid_out, ks.round_idx_out); end
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ks.round_key_valid_out !== 1'b0 || ks.busy_out !== 1'b0 || ks.round_idx_out !== 4'd0 ||
        ks.round_key_out !== 128'd0 || ks.subword_out !== 32'd0 || ks.done_out !== 1'b0 || ks.err_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_async valid=%b busy=%b idx=%0d key=%h subword=%h done=%b err=%b want all 0",
               ks.round_key_valid_out, ks.busy_out, ks.round_idx_out, ks.round_key_out, ks.subword_out,
               ks.done_out, ks.err_out);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", done_cnt - d0); end
    ks.round_key_ready_in = 1'b1;
    start_run(2'b00, KEY128);
    wait_done(300, d0);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL rst_rerun_done got=%0d want=1", done_cnt - d0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_rerun_keys_left got=%0d want=0", exp_q.size()); end
    total++; if (last_key !== k10) begin bad++; $display("FAIL rst_rerun_key10 got=%h want=%h", last_key, k10); end
    $display("reset mid-run complete");
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
